clk_freq_monitor: RTL and testbench

CLK_FREQ_MONITOR -- requirements
Module: clk_freq_monitor

---
 rtl/clk_freq_monitor.sv | 149 ++++++++++++++
 tb/tb_clk_freq_monitor.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_freq_monitor.sv
// Measures the period of a slow clock (clk_in) in clk_50M cycles, checks it against
// an expected value with tolerance, and reports lock, per-period faults and stuck input.
module clk_freq_monitor #(
    parameter int EXP_PERIOD = 16,
    parameter int TOL        = 1,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic       en,
    input  logic       clk_in,
    output logic [7:0] period,
    output logic       period_valid,
    output logic       fault,
    output logic       locked,
    output logic       stuck
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        MEASURE = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    localparam logic [7:0] PER_LO    = 8'(EXP_PERIOD - TOL);
    localparam logic [7:0] PER_HI    = 8'(EXP_PERIOD + TOL);
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [2:0] LOCK_C    = 3'(LOCK_CNT);

    state_t     state_reg, state_next;
    logic [2:0] sync_reg;
    logic [7:0] cnt_reg, cnt_next;
    logic [2:0] good_reg, good_next;
    logic [7:0] period_reg, period_next;
    logic       period_valid_reg, period_valid_next;
    logic       fault_reg, fault_next;
    logic       locked_reg, locked_next;
    logic       stuck_reg, stuck_next;

    logic       edge_det;
    logic       in_range;
    logic       timeout_hit;
    logic [2:0] good_inc;
    logic [7:0] cnt_inc;

    // Two metastability flops, then a third to form the rising-edge detector.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            sync_reg <= 3'b000;
        end else begin
            sync_reg <= {sync_reg[1:0], clk_in};
        end
    end

    assign edge_det    = sync_reg[1] & ~sync_reg[2];
    assign in_range    = (cnt_reg >= PER_LO) && (cnt_reg <= PER_HI);
    assign timeout_hit = (cnt_reg == TIMEOUT_C);
    assign good_inc    = (good_reg == 3'd7) ? good_reg : good_reg + 3'd1;
    assign cnt_inc     = (cnt_reg == 8'hFF) ? cnt_reg : cnt_reg + 8'd1;

    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        good_next         = good_reg;
        period_next       = period_reg;
        period_valid_next = 1'b0;
        fault_next        = 1'b0;
        stuck_next        = stuck_reg;

        if (!en) begin
            // Disable drops lock state but keeps the last period and stuck flag.
            state_next = IDLE;
            cnt_next   = 8'd0;
            good_next  = 3'd0;
        end else begin
            cnt_next = edge_det ? 8'd1 : cnt_inc;
            case (state_reg)
                IDLE: begin
                    state_next = ACQUIRE;
                    cnt_next   = 8'd0;
                end
                ACQUIRE: begin
                    // First edge only starts the interval; nothing is measured yet.
                    if (edge_det) begin
                        state_next = MEASURE;
                        stuck_next = 1'b0;
                    end
                end
                MEASURE, LOCKED: begin
                    // An edge wins over a coincident timeout.
                    if (edge_det) begin
                        period_next       = cnt_reg;
                        period_valid_next = 1'b1;
                        if (in_range) begin
                            good_next = good_inc;
                            if (good_inc >= LOCK_C) begin
                                state_next = LOCKED;
                            end
                        end else begin
                            fault_next = 1'b1;
                            good_next  = 3'd0;
                            state_next = MEASURE;
                        end
                    end else if (timeout_hit) begin
                        stuck_next = 1'b1;
                        good_next  = 3'd0;
                        state_next = ACQUIRE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        locked_next = (state_next == LOCKED);
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            cnt_reg          <= 8'd0;
            good_reg         <= 3'd0;
            period_reg       <= 8'd0;
            period_valid_reg <= 1'b0;
            fault_reg        <= 1'b0;
            locked_reg       <= 1'b0;
            stuck_reg        <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            good_reg         <= good_next;
            period_reg       <= period_next;
            period_valid_reg <= period_valid_next;
            fault_reg        <= fault_next;
            locked_reg       <= locked_next;
            stuck_reg        <= stuck_next;
        end
    end

    assign period       = period_reg;
    assign period_valid = period_valid_reg;
    assign fault        = fault_reg;
    assign locked       = locked_reg;
    assign stuck        = stuck_reg;

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Directed bench for clk_freq_monitor: stimulus pushes expected measurements into a
// queue, a negedge monitor pops and compares them on every period_valid pulse.
module tb_clk_freq_monitor;

    logic       clk_50M;
    logic       rst;
    logic       en;
    logic       clk_in;
    logic [7:0] period;
    logic       period_valid;
    logic       fault;
    logic       locked;
    logic       stuck;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_pv_cyc = 0;

    typedef struct {
        int p;
        bit f;
        bit l;
    } exp_t;

    exp_t exp_q[$];

    clk_freq_monitor #(
        .EXP_PERIOD(16),
        .TOL(1),
        .LOCK_CNT(4),
        .TIMEOUT(64)
    ) dut (
        .clk_50M(clk_50M),
        .rst(rst),
        .en(en),
        .clk_in(clk_in),
        .period(period),
        .period_valid(period_valid),
        .fault(fault),
        .locked(locked),
        .stuck(stuck)
    );

    initial clk_50M = 1'b0;
    always #10 clk_50M = ~clk_50M;

    always @(posedge clk_50M) cyc++;

    // Scoreboard monitor
    always @(negedge clk_50M) begin
        if (!rst) begin
            if (fault && !period_valid) begin
                n_tests++;
                n_fail++;
                $display("FAIL fault_without_valid: fault=1 period_valid=0 at cycle %0d", cyc);
            end
            if (period_valid) begin
                last_pv_cyc = cyc;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_valid: period=%0d fault=%0b locked=%0b, none expected", period, fault, locked);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (period != e.p[7:0] || fault != e.f || locked != e.l) begin
                        n_fail++;
                        $display("FAIL measurement: got period=%0d fault=%0b locked=%0b, want period=%0d fault=%0b locked=%0b",
                                 period, fault, locked, e.p, e.f, e.l);
                    end else begin
                        $display("[TB] measurement period=%0d fault=%0b locked=%0b ok", period, fault, locked);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, actual, expected);
        end else begin
            $display("[TB] %s = %0d ok", name, actual);
        end
    endtask

    // One clk_in period of n cycles starting with a rise; the rise completes the
    // previous interval, whose expected result (if any) is queued first.
    task automatic send(input int n, input bit meas, input int ep, input bit ef, input bit el);
        if (meas) exp_q.push_back('{ep, ef, el});
        clk_in = 1'b1;
        repeat (n / 2) @(negedge clk_50M);
        clk_in = 1'b0;
        repeat (n - n / 2) @(negedge clk_50M);
    endtask

    task automatic relock_16();
        send(16, 0, 0, 0, 0);
        repeat (3) send(16, 1, 16, 0, 0);
        send(16, 1, 16, 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst = 1'b1;
        en = 1'b0;
        clk_in = 1'b0;
        repeat (3) @(negedge clk_50M);
        check("reset_period", period, 0);
        check("reset_period_valid", period_valid, 0);
        check("reset_fault", fault, 0);
        check("reset_locked", locked, 0);
        check("reset_stuck", stuck, 0);
        rst = 1'b0;
        en = 1'b1;
        repeat (3) @(negedge clk_50M);

        // Nominal period 16, lock on the 4th measurement.
        relock_16();
        // Alternate 17/15: all in tolerance, lock held.
        send(17, 1, 16, 0, 1);
        send(15, 1, 17, 0, 1);
        send(17, 1, 15, 0, 1);
        send(15, 1, 17, 0, 1);
        // Period 18: every measurement faults, lock lost and never regained.
        send(18, 1, 15, 0, 1);
        repeat (3) send(18, 1, 18, 1, 0);
        send(16, 1, 18, 1, 0);
        repeat (3) send(16, 1, 16, 0, 0);
        send(16, 1, 16, 0, 1);

        // clk_in stops: stuck 64 cycles after the last measurement.
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_50M);
            if (stuck) begin
                found = 1'b1;
                break;
            end
        end
        check("stuck_seen", found, 1);
        check("stuck_delay", cyc - last_pv_cyc, 64);
        check("stuck_locked", locked, 0);
        send(16, 0, 0, 0, 0);
        check("stuck_cleared", stuck, 0);
        repeat (3) send(16, 1, 16, 0, 0);
        send(16, 1, 16, 0, 1);

        // Single long period while locked.
        send(20, 1, 16, 0, 1);
        send(16, 1, 20, 1, 0);
        repeat (3) send(16, 1, 16, 0, 0);
        send(16, 1, 16, 0, 1);

        // Asynchronous reset mid-lock.
        repeat (2) @(negedge clk_50M);
        check("pre_rst_locked", locked, 1);
        @(posedge clk_50M);
        #3 rst = 1'b1;
        #1;
        check("rst_period", period, 0);
        check("rst_locked", locked, 0);
        check("rst_valid", period_valid, 0);
        check("rst_fault", fault, 0);
        repeat (2) @(negedge clk_50M);
        rst = 1'b0;
        repeat (2) @(negedge clk_50M);
        relock_16();

        // Enable dropped for 10 cycles with clk_in still toggling.
        en = 1'b0;
        clk_in = 1'b1;
        repeat (8) @(negedge clk_50M);
        clk_in = 1'b0;
        repeat (2) @(negedge clk_50M);
        check("en_off_locked", locked, 0);
        en = 1'b1;
        repeat (3) @(negedge clk_50M);
        relock_16();

        // Period exactly TIMEOUT: the edge wins, measured 64 and faulted, no stuck.
        send(64, 1, 16, 0, 1);
        send(16, 1, 64, 1, 0);
        check("coincide_stuck", stuck, 0);

        repeat (10) @(negedge clk_50M);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
